// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
package dmem_arb_pkg;

  // Transaction sequencer states.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    RESP
  } state_t;

  // Requester identifiers; the value doubles as the grant bit index.
  typedef enum logic {
    REQ_LS  = 1'b0,
    REQ_STK = 1'b1
  } req_id_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int CNT_W          = 2;

  // Selects byte k of a word, big-endian (k = 0 is bits 31:24).
  function automatic logic [7:0] word_byte(input logic [31:0] w,
                                           input logic [CNT_W-1:0] k);
    case (k)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

endpackage

// File: rtl/dmem_rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins a
// tie and flips to the other requester after every accepted grant.
module dmem_rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant
);

  req_id_t ptr;

  // Grant selection: a lone request wins outright, a tie goes to the pointer.
  always_comb begin
    // NOTE: give every combinational output a default first so no path leaves it unassigned (latch).
    grant = 2'b00;
    if (valid == 2'b11) begin
      grant = (ptr == REQ_LS) ? 2'b01 : 2'b10;
    end else begin
      grant = valid;
    end
  end

  // Pointer update: after a grant, favour the requester that did not win.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    if (rst) begin
      ptr <= REQ_LS;
    end else if (accept) begin
      ptr <= grant[0] ? REQ_STK : REQ_LS;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: serialises 32-bit LS and STK word accesses onto a
// byte-wide synchronous memory port, four byte cycles per word, big-endian.
// Optional: define DMEM_ARB_ALIGN_CHECK_EN to reject word-misaligned
// addresses with an error response and no memory cycles.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ls_valid,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ready,
  output logic              ls_rsp_valid,
  output logic              ls_rsp_err,
  input  logic              stk_valid,
  input  logic              stk_we,
  input  logic [ADDR_W-1:0] stk_addr,
  input  logic [DATA_W-1:0] stk_wdata,
  output logic              stk_ready,
  output logic              stk_rsp_valid,
  output logic              stk_rsp_err,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  input  logic [7:0]        mem_rdata
);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  req_id_t           owner;
  logic              lat_we;
  logic [DATA_W-1:0] lat_wdata;
  logic [23:0]       rd_buf;

  logic [1:0]        grant;
  logic              accept;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_misaligned;

  // Requests are only considered while idle; ready is the idle-gated grant.
  assign accept    = (state == IDLE) && (ls_valid || stk_valid);
  assign ls_ready  = accept && grant[REQ_LS];
  assign stk_ready = accept && grant[REQ_STK];
  assign busy      = (state != IDLE);

  assign win_we    = grant[REQ_STK] ? stk_we    : ls_we;
  assign win_addr  = grant[REQ_STK] ? stk_addr  : ls_addr;
  assign win_wdata = grant[REQ_STK] ? stk_wdata : ls_wdata;

`ifdef DMEM_ARB_ALIGN_CHECK_EN
  assign win_misaligned = (win_addr[1:0] != 2'b00);
`else
  assign win_misaligned = 1'b0;
  assign ls_rsp_err     = 1'b0;
  assign stk_rsp_err    = 1'b0;
`endif

  dmem_rr_arb2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .valid  ({stk_valid, ls_valid}),
    .accept (accept),
    .grant  (grant)
  );

  // Transaction sequencer with registered memory-port and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      cnt           <= '0;
      owner         <= REQ_LS;
      lat_we        <= 1'b0;
      lat_wdata     <= '0;
      rd_buf        <= '0;
      rsp_rdata     <= '0;
      ls_rsp_valid  <= 1'b0;
      stk_rsp_valid <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      ls_rsp_err    <= 1'b0;
      stk_rsp_err   <= 1'b0;
`endif
      mem_en        <= 1'b0;
      mem_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
    end else begin
      // Response strobes are single-cycle pulses unless re-armed below.
      ls_rsp_valid  <= 1'b0;
      stk_rsp_valid <= 1'b0;
`ifdef DMEM_ARB_ALIGN_CHECK_EN
      ls_rsp_err    <= 1'b0;
      stk_rsp_err   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            owner     <= grant[REQ_STK] ? REQ_STK : REQ_LS;
            lat_we    <= win_we;
            lat_wdata <= win_wdata;
            cnt       <= '0;
            if (win_misaligned) begin
              // Rejected request: answer directly, memory is never touched.
              state         <= RESP;
              ls_rsp_valid  <= grant[REQ_LS];
              stk_rsp_valid <= grant[REQ_STK];
`ifdef DMEM_ARB_ALIGN_CHECK_EN
              ls_rsp_err    <= grant[REQ_LS];
              stk_rsp_err   <= grant[REQ_STK];
`endif
            end else begin
              state     <= ISSUE;
              mem_en    <= 1'b1;
              mem_we    <= win_we;
              mem_addr  <= win_addr;
              mem_wdata <= word_byte(win_wdata, 2'd0);
            end
          end
        end
        ISSUE: begin
          // Read byte k-1 arrives while byte k is being issued.
          if (!lat_we && (cnt != 2'd0)) begin
            rd_buf <= {rd_buf[15:0], mem_rdata};
          end
          if (cnt == CNT_W'(BYTES_PER_WORD - 1)) begin
            state  <= DRAIN;
            mem_en <= 1'b0;
            mem_we <= 1'b0;
          end else begin
            cnt       <= cnt + 2'd1;
            mem_addr  <= mem_addr + ADDR_W'(1);
            mem_wdata <= word_byte(lat_wdata, cnt + 2'd1);
          end
        end
        DRAIN: begin
          // Last read byte lands here; writes just spend the same cycle.
          if (!lat_we) begin
            rsp_rdata <= {rd_buf, mem_rdata};
          end
          state         <= RESP;
          ls_rsp_valid  <= (owner == REQ_LS);
          stk_rsp_valid <= (owner == REQ_STK);
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a byte memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ls_valid, ls_we, ls_ready, ls_rsp_valid, ls_rsp_err;
  logic [4:0]  ls_addr;
  logic [31:0] ls_wdata;
  logic        stk_valid, stk_we, stk_ready, stk_rsp_valid, stk_rsp_err;
  logic [4:0]  stk_addr;
  logic [31:0] stk_wdata;
  logic [31:0] rsp_rdata;
  logic        busy, mem_en, mem_we;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  // Memory model with a preload port and an access log.
  logic [7:0] mem [32];
  logic       ld_en = 1'b0;
  logic [4:0] ld_addr;
  logic [7:0] ld_data;
  logic [4:0] log_addr [128];
  logic       log_we   [128];
  logic [7:0] log_wd   [128];
  int         log_n = 0;

  dmem_arbiter #(.ADDR_W(5), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .ls_valid(ls_valid), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ready(ls_ready), .ls_rsp_valid(ls_rsp_valid), .ls_rsp_err(ls_rsp_err),
    .stk_valid(stk_valid), .stk_we(stk_we), .stk_addr(stk_addr), .stk_wdata(stk_wdata),
    .stk_ready(stk_ready), .stk_rsp_valid(stk_rsp_valid), .stk_rsp_err(stk_rsp_err),
    .rsp_rdata(rsp_rdata), .busy(busy),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
      log_addr[log_n % 128] <= mem_addr;
      log_we[log_n % 128]   <= mem_we;
      log_wd[log_n % 128]   <= mem_wdata;
      log_n <= log_n + 1;
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic load_byte(input logic [4:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents a request and returns one ns after the handshake edge.
  task automatic send(input bit stk, input bit we, input logic [4:0] addr,
                      input logic [31:0] wd, output bit ok);
    @(negedge clk);
    if (stk) begin stk_valid = 1'b1; stk_we = we; stk_addr = addr; stk_wdata = wd; end
    else     begin ls_valid  = 1'b1; ls_we  = we; ls_addr  = addr; ls_wdata  = wd; end
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      #1;
      if (stk ? stk_ready : ls_ready) ok = 1'b1;
      else @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1;
    if (stk) stk_valid = 1'b0; else ls_valid = 1'b0;
  endtask

  // Counts cycles after the handshake until the response; idx 0 means none.
  task automatic wait_rsp(input bit stk, output int idx, output bit other, output bit err);
    idx = 0; other = 1'b0; err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (stk ? ls_rsp_valid : stk_rsp_valid) other = 1'b1;
      if (stk ? stk_rsp_valid : ls_rsp_valid) begin
        idx = i;
        err = stk ? stk_rsp_err : ls_rsp_err;
        break;
      end
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({ls_ready, stk_ready, ls_rsp_valid, stk_rsp_valid, ls_rsp_err, stk_rsp_err,
         busy, mem_en, mem_we} !== 9'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 000000000",
               {ls_ready, stk_ready, ls_rsp_valid, stk_rsp_valid, ls_rsp_err,
                stk_rsp_err, busy, mem_en, mem_we});
    end
    checks++;
    if ({rsp_rdata, mem_addr, mem_wdata} !== 45'h0) begin
      errors++;
      $display("FAIL reset_data: rdata=%h addr=%0d wdata=%h expected all zero",
               rsp_rdata, mem_addr, mem_wdata);
    end
  endtask

  task automatic test_ls_read();
    bit ok, other, err; int idx, s;
    s = log_n;
    send(1'b0, 1'b0, 5'd4, 32'h0, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL ls_read_ready: got %b expected 1", ok); end
    wait_rsp(1'b0, idx, other, err);
    checks++;
    if (idx !== 6) begin errors++; $display("FAIL ls_read_latency: got %0d expected 6", idx); end
    checks++;
    if (rsp_rdata !== 32'h11223344) begin
      errors++; $display("FAIL ls_read_data: got %h expected 11223344", rsp_rdata);
    end
    checks++;
    if ({other, err} !== 2'b00) begin
      errors++; $display("FAIL ls_read_side: stk_rsp/err got %b expected 00", {other, err});
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({log_addr[(s + k) % 128], log_we[(s + k) % 128]} !== {5'(4 + k), 1'b0}) begin
        errors++;
        $display("FAIL ls_read_issue%0d: addr=%0d we=%b expected addr=%0d we=0",
                 k, log_addr[(s + k) % 128], log_we[(s + k) % 128], 4 + k);
      end
    end
    checks++;
    if (log_n - s !== 4) begin errors++; $display("FAIL ls_read_count: got %0d expected 4", log_n - s); end
  endtask

  task automatic test_stk_write();
    bit ok, other, err; int idx, s;
    logic [7:0] exp_b [4];
    exp_b[0] = 8'hDE; exp_b[1] = 8'hAD; exp_b[2] = 8'hBE; exp_b[3] = 8'hEF;
    s = log_n;
    send(1'b1, 1'b1, 5'd8, 32'hDEADBEEF, ok);
    checks++;
    if (ok !== 1'b1) begin errors++; $display("FAIL stk_write_ready: got %b expected 1", ok); end
    wait_rsp(1'b1, idx, other, err);
    checks++;
    if (idx !== 6) begin errors++; $display("FAIL stk_write_latency: got %0d expected 6", idx); end
    checks++;
    if ({other, err} !== 2'b00) begin
      errors++; $display("FAIL stk_write_side: ls_rsp/err got %b expected 00", {other, err});
    end
    checks++;
    if (rsp_rdata !== 32'h11223344) begin
      errors++; $display("FAIL stk_write_rdata_hold: got %h expected 11223344", rsp_rdata);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if ({log_addr[(s + k) % 128], log_we[(s + k) % 128], log_wd[(s + k) % 128]} !==
          {5'(8 + k), 1'b1, exp_b[k]}) begin
        errors++;
        $display("FAIL stk_write_issue%0d: addr=%0d we=%b data=%h expected addr=%0d we=1 data=%h",
                 k, log_addr[(s + k) % 128], log_we[(s + k) % 128], log_wd[(s + k) % 128],
                 8 + k, exp_b[k]);
      end
    end
  endtask

  task automatic test_arbitration();
    bit other, err; int idx;
    apply_reset();
    @(negedge clk);
    ls_valid = 1'b1;  ls_we = 1'b0;  ls_addr = 5'd4;
    stk_valid = 1'b1; stk_we = 1'b0; stk_addr = 5'd8;
    #1;
    checks++;
    if ({ls_ready, stk_ready} !== 2'b10) begin
      errors++; $display("FAIL arb_first: ls/stk ready got %b expected 10", {ls_ready, stk_ready});
    end
    @(posedge clk); #1; ls_valid = 1'b0;
    wait_rsp(1'b0, idx, other, err);
    checks++;
    if ({idx, stk_ready} !== {32'd6, 1'b0}) begin
      errors++; $display("FAIL arb_ls_rsp: idx=%0d stk_ready=%b expected idx=6 stk_ready=0", idx, stk_ready);
    end
    @(negedge clk); #1;
    checks++;
    if ({ls_ready, stk_ready} !== 2'b01) begin
      errors++; $display("FAIL arb_second: ls/stk ready got %b expected 01", {ls_ready, stk_ready});
    end
    @(posedge clk); #1; stk_valid = 1'b0;
    wait_rsp(1'b1, idx, other, err);
    checks++;
    if ({idx, rsp_rdata} !== {32'd6, 32'hDEADBEEF}) begin
      errors++; $display("FAIL arb_stk_rsp: idx=%0d data=%h expected idx=6 data=deadbeef", idx, rsp_rdata);
    end
    @(negedge clk);
    ls_valid = 1'b1; stk_valid = 1'b1;
    #1;
    checks++;
    if ({ls_ready, stk_ready} !== 2'b10) begin
      errors++; $display("FAIL arb_third: ls/stk ready got %b expected 10", {ls_ready, stk_ready});
    end
    @(posedge clk); #1; ls_valid = 1'b0; stk_valid = 1'b0;
    wait_rsp(1'b0, idx, other, err);
    checks++;
    if (idx !== 6) begin errors++; $display("FAIL arb_third_rsp: got %0d expected 6", idx); end
  endtask

`ifndef DMEM_ARB_ALIGN_CHECK_EN
  task automatic test_wrap();
    bit ok, other, err; int idx, s;
    logic [4:0] exp_a [4];
    exp_a[0] = 5'd30; exp_a[1] = 5'd31; exp_a[2] = 5'd0; exp_a[3] = 5'd1;
    s = log_n;
    send(1'b0, 1'b0, 5'd30, 32'h0, ok);
    wait_rsp(1'b0, idx, other, err);
    checks++;
    if ({ok, idx, rsp_rdata} !== {1'b1, 32'd6, 32'hA1B2C3D4}) begin
      errors++;
      $display("FAIL wrap_read: ok=%b idx=%0d data=%h expected ok=1 idx=6 data=a1b2c3d4", ok, idx, rsp_rdata);
    end
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (log_addr[(s + k) % 128] !== exp_a[k]) begin
        errors++;
        $display("FAIL wrap_addr%0d: got %0d expected %0d", k, log_addr[(s + k) % 128], exp_a[k]);
      end
    end
  endtask
`else
  task automatic test_align();
    bit ok, other, err; int idx, s;
    logic [31:0] prev;
    prev = rsp_rdata;
    s = log_n;
    send(1'b0, 1'b0, 5'd5, 32'h0, ok);
    wait_rsp(1'b0, idx, other, err);
    checks++;
    if ({ok, idx, err} !== {1'b1, 32'd1, 1'b1}) begin
      errors++; $display("FAIL align_err: ok=%b idx=%0d err=%b expected ok=1 idx=1 err=1", ok, idx, err);
    end
    checks++;
    if ({log_n - s, rsp_rdata} !== {32'd0, prev}) begin
      errors++; $display("FAIL align_nomem: mem cycles=%0d data=%h expected 0 and %h", log_n - s, rsp_rdata, prev);
    end
    send(1'b0, 1'b0, 5'd4, 32'h0, ok);
    wait_rsp(1'b0, idx, other, err);
    checks++;
    if ({idx, err, rsp_rdata} !== {32'd6, 1'b0, 32'h11223344}) begin
      errors++; $display("FAIL align_ok: idx=%0d err=%b data=%h expected 6 0 11223344", idx, err, rsp_rdata);
    end
  endtask
`endif

  task automatic test_reset_mid_write();
    bit ok, other, err, seen; int idx;
    send(1'b0, 1'b1, 5'd12, 32'hCAFEF00D, ok);
    repeat (3) @(negedge clk);
    checks++;
    if ({mem_en, mem_addr} !== {1'b1, 5'd14}) begin
      errors++; $display("FAIL rstmid_pre: en=%b addr=%0d expected en=1 addr=14", mem_en, mem_addr);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_en, mem_we, busy, mem_addr} !== 8'b0) begin
      errors++; $display("FAIL rstmid_async: en=%b we=%b busy=%b addr=%0d expected all 0", mem_en, mem_we, busy, mem_addr);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (ls_rsp_valid || stk_rsp_valid) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rstmid_norsp: got %b expected 0", seen); end
    checks++;
    if ({mem[12], mem[13], mem[14], mem[15]} !== 32'hCAFE5A5B) begin
      errors++; $display("FAIL rstmid_mem: got %h expected cafe5a5b", {mem[12], mem[13], mem[14], mem[15]});
    end
    send(1'b0, 1'b0, 5'd12, 32'h0, ok);
    wait_rsp(1'b0, idx, other, err);
    checks++;
    if ({ok, idx, rsp_rdata} !== {1'b1, 32'd6, 32'hCAFE5A5B}) begin
      errors++; $display("FAIL rstmid_recover: ok=%b idx=%0d data=%h expected 1 6 cafe5a5b", ok, idx, rsp_rdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    ls_valid = 1'b0;  ls_we = 1'b0;  ls_addr = '0;  ls_wdata = '0;
    stk_valid = 1'b0; stk_we = 1'b0; stk_addr = '0; stk_wdata = '0;
    load_byte(5'd4, 8'h11);  load_byte(5'd5, 8'h22);
    load_byte(5'd6, 8'h33);  load_byte(5'd7, 8'h44);
    load_byte(5'd30, 8'hA1); load_byte(5'd31, 8'hB2);
    load_byte(5'd0, 8'hC3);  load_byte(5'd1, 8'hD4);
    load_byte(5'd12, 8'h00); load_byte(5'd13, 8'h00);
    load_byte(5'd14, 8'h5A); load_byte(5'd15, 8'h5B);
    @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_ls_read();
    test_stk_write();
    test_arbitration();
`ifndef DMEM_ARB_ALIGN_CHECK_EN
    test_wrap();
`else
    test_align();
`endif
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
Shares the single byte-wide data memory port between two word requesters: the load/store path (LS) and the jump-stack path (STK, push/pop of return PC).
- Each 32-bit access is serialized into four byte cycles, big-endian (lowest address = bits 31:24).
- Two-way round-robin grant; registered per-requester response.
- Sits between the processor datapath and the data memory array.

Parameters:
ADDR_W, 5, byte address width (memory depth 2**ADDR_W bytes)
DATA_W, 32, word width; fixed at 32, 4 bytes per word

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-high reset
ls_valid  in  1  LS request valid
ls_we  in  1  LS write (1) / read (0)
ls_addr  in  ADDR_W  LS byte address of word's MSB byte
ls_wdata  in  32  LS store data
ls_ready  out  1  LS request accepted this cycle
ls_rsp_valid  out  1  LS one-cycle completion pulse
ls_rsp_err  out  1  LS error flag, valid with ls_rsp_valid
stk_valid, stk_we, stk_addr, stk_wdata, stk_ready, stk_rsp_valid, stk_rsp_err  same as ls_* for STK
rsp_rdata  out  32  read data, valid with either rsp_valid
busy  out  1  high in any state except IDLE
mem_en  out  1  memory byte access enable
mem_we  out  1  memory byte write enable
mem_addr  out  ADDR_W  memory byte address
mem_wdata  out  8  memory write byte
mem_rdata  in  8  memory read byte, 1-cycle synchronous latency after mem_en

Behaviour:
- Reset values: state IDLE, byte counter 0, rr pointer = LS, all *_ready/*_rsp_valid/*_rsp_err/mem_en/mem_we/busy = 0, rsp_rdata = 0, mem_addr/mem_wdata = 0.
- States: IDLE -> ISSUE (4 cycles, cnt 0..3) -> DRAIN (1 cycle) -> RESP (1 cycle) -> IDLE.
- IDLE: if any valid, the winner's ready = 1 combinationally. Its we/addr/wdata and owner ID are latched on that edge. Go to ISSUE. Requester holds fields stable only until ready.
- Arbitration: only one valid -> it wins. Both valid -> the rr pointer wins. After any grant the pointer points to the other requester. ready is never asserted outside IDLE.
- ISSUE cnt k:
  - mem_en = 1, mem_addr = latched addr + k modulo 2**ADDR_W (wraps 31 -> 0).
  - mem_we = latched we; mem_wdata = wdata byte k (k=0 -> bits 31:24).
  - For reads, the byte returned in the cycle after issue k is captured into word byte k.
- DRAIN: mem_en = 0; captures byte 3 (reads); write path idles the same cycle, so latency is uniform.
- RESP: owner's rsp_valid = 1 for exactly one cycle. rsp_rdata holds the assembled word (reads) or the unchanged previous value (writes); err = 0.
- Latency: handshake at edge T -> rsp_valid high in cycle T+6. Next accept is possible at earliest in the IDLE cycle after RESP, so throughput is 1 word / 7 cycles.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous). No response is issued. Bytes already written stay written; a partial store is permitted.
- Valid dropped before ready: no request and no effect.

Optional Feature:
DMEM_ARB_ALIGN_CHECK_EN
- Defined: a request with addr[1:0] != 0 is accepted but issues no memory cycles. It goes IDLE -> RESP, and the owner gets rsp_valid with rsp_err = 1 one cycle after the handshake; rsp_rdata is unchanged.
- Undefined: any address is legal (wrap applies); *_rsp_err is tied to 0.

Decomposition:
- Package dmem_arb_pkg:
  - State enum (IDLE, ISSUE, DRAIN, RESP).
  - Requester ID enum (REQ_LS, REQ_STK).
  - BYTES_PER_WORD = 4, CNT_W = 2.
- Sub-module dmem_rr_arb2: 2-way round-robin arbiter with pointer register. Inputs: valid pair, grant-accept strobe. Outputs: one-hot grant.

Test Plan:
- LS read addr 4, memory bytes 4..7 = 11,22,33,44 -> mem_addr 4,5,6,7 with mem_we 0; ls_rsp_valid at T+6; rsp_rdata 0x11223344; stk_rsp_valid stays 0.
- STK write addr 8, data 0xDEADBEEF -> byte writes 8:DE, 9:AD, 10:BE, 11:EF; stk_rsp_valid at T+6.
- ls_valid and stk_valid both high after reset -> LS granted first, STK granted in the next IDLE. Repeat with both high again -> LS granted, confirming alternation.
- LS read addr 30 (macro off), bytes 30,31,0,1 = A1,B2,C3,D4 -> mem_addr sequence 30,31,0,1; rsp_rdata 0xA1B2C3D4.
- rst pulsed during ISSUE cnt 2 of a write to 12 -> mem_en/busy drop without waiting for a clock; no rsp_valid; bytes 12,13 written, 14,15 untouched; next request is served normally.
- Macro on, LS read addr 5 -> no mem_en; ls_rsp_valid with ls_rsp_err = 1 one cycle after handshake. Addr 4 -> normal path, err = 0.
